// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, control states
// and the alignment rule used by both the datapath and the control FSM.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // The reserved size encoding always faults so it can never touch memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = offset[0];
            SZ_WORD: fault = |offset;
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: merges store data into a word and extracts/extends
// load data from a word. Byte offset 0 maps to bits [31:24].
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Store path: replace only the addressed lane of the old word.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    2'd3:    merged[7:0]   = wdata[7:0];
                    default: merged        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[15:0] = wdata[15:0];
                end else begin
                    merged[31:16] = wdata[15:0];
                end
            end
            SZ_WORD: merged = wdata;
            default: merged = old_word;
        endcase
    end

    // Load lane selection, before extension.
    always_comb begin
        byte_sel_s = 8'h00;
        case (offset)
            2'd0:    byte_sel_s = rd_word[31:24];
            2'd1:    byte_sel_s = rd_word[23:16];
            2'd2:    byte_sel_s = rd_word[15:8];
            2'd3:    byte_sel_s = rd_word[7:0];
            default: byte_sel_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_sel_s = rd_word[15:0];
        end else begin
            half_sel_s = rd_word[31:16];
        end
    end

    // Right-justify and extend from the lane MSB; word loads pass through.
    always_comb begin
        rdata = 32'h0000_0000;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & byte_sel_s[7]}}, byte_sel_s};
            SZ_HALF: rdata = {{16{sign_ext & half_sel_s[15]}}, half_sel_s};
            SZ_WORD: rdata = rd_word;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// MEM-stage data memory with programmable read latency, valid/ready handshake
// and a post-reset initialisation sweep over the whole word array.
module data_mem_sized
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int LATENCY    = 1,
    parameter int INIT_WORDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        init_done
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = 4;

    logic [31:0]       mem_r [DEPTH];
    state_t            state_r, state_next_s;
    logic [IDX_W-1:0]  init_ptr_r;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              accept_s;

    logic              we_r, sign_ext_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              cur_we_s, cur_sign_ext_s;
    logic [1:0]        cur_size_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [31:0]       cur_wdata_s;
    logic [IDX_W-1:0]  cur_idx_s;

    logic [31:0]       rd_word_s, merged_s, lane_rdata_s, load_val_s;
    logic              err_s;

    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_widx_s;
    logic [31:0]       mem_wdata_s;

    logic              req_ready_r, rvalid_r, misalign_r, init_done_r;
    logic [31:0]       rdata_r;
    logic              addr_unused_s;

    assign addr_unused_s = ^addr[31:ADDR_W];

    // In IDLE the response may be produced at the accept edge (LATENCY==1),
    // so the live request ports stand in for the not-yet-latched copy.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s       = we;
            cur_size_s     = size;
            cur_sign_ext_s = sign_ext;
            cur_addr_s     = addr[ADDR_W-1:0];
            cur_wdata_s    = wdata;
        end else begin
            cur_we_s       = we_r;
            cur_size_s     = size_r;
            cur_sign_ext_s = sign_ext_r;
            cur_addr_s     = addr_r;
            cur_wdata_s    = wdata_r;
        end
    end

    assign cur_idx_s = cur_addr_s[ADDR_W-1:2];
    assign rd_word_s = mem_r[cur_idx_s];
    assign err_s     = is_misaligned(cur_size_s, cur_addr_s[1:0]);

    mem_lane_align u_lane (
        .old_word (rd_word_s),
        .wdata    (cur_wdata_s),
        .rd_word  (rd_word_s),
        .size     (cur_size_s),
        .offset   (cur_addr_s[1:0]),
        .sign_ext (cur_sign_ext_s),
        .merged   (merged_s),
        .rdata    (lane_rdata_s)
    );

    assign load_val_s = (cur_we_s || err_s) ? 32'h0000_0000 : lane_rdata_s;

    // Next-state logic for the init / handshake / latency FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            INIT: begin
                if (init_ptr_r == IDX_W'(DEPTH - 1)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = INIT;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = CNT_W'(LATENCY - 2);
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = INIT;
        endcase
    end

    // Control state, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT;
            init_ptr_r  <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            sign_ext_r  <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0000_0000;
            req_ready_r <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            misalign_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (state_r == INIT) begin
                init_ptr_r <= init_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (state_r == INIT && state_next_s == IDLE) begin
                init_done_r <= 1'b1;
            end
            if (accept_s) begin
                we_r       <= we;
                size_r     <= size;
                sign_ext_r <= sign_ext;
                addr_r     <= addr[ADDR_W-1:0];
                wdata_r    <= wdata;
            end
            req_ready_r <= (state_next_s == IDLE);
            rvalid_r    <= (state_next_s == RESP);
            rdata_r     <= (state_next_s == RESP) ? load_val_s : 32'h0000_0000;
            misalign_r  <= (state_next_s == RESP) ? err_s : 1'b0;
        end
    end

    // Single write port: init sweep, or store commit on the edge leaving RESP.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_widx_s  = {IDX_W{1'b0}};
        mem_wdata_s = 32'h0000_0000;
        if (rst) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    mem_we_s    = 1'b1;
                    mem_widx_s  = init_ptr_r;
                    mem_wdata_s = (32'(init_ptr_r) < 32'(INIT_WORDS)) ? 32'(init_ptr_r) : 32'h0000_0000;
                end
                RESP: begin
                    if (we_r && !err_s) begin
                        mem_we_s    = 1'b1;
                        mem_widx_s  = cur_idx_s;
                        mem_wdata_s = merged_s;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: mem_we_s = 1'b0;
            endcase
        end
    end

    // Word array storage.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_widx_s] <= mem_wdata_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign misalign  = misalign_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_data_mem_sized.sv
// Self-checking bench for data_mem_sized: directed scenarios plus randomized
// accesses compared against a byte-array reference model.
module tb_data_mem_sized;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst, req_valid, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        req_ready, rvalid, misalign, init_done;
    logic [31:0] rdata;

    logic        rst1, req_valid1, we1, sign_ext1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1;
    logic        req_ready1, rvalid1, misalign1, init_done1;
    logic [31:0] rdata1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    data_mem_sized #(.ADDR_W(8), .LATENCY(LAT), .INIT_WORDS(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .we(we), .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rvalid(rvalid), .rdata(rdata), .misalign(misalign), .init_done(init_done)
    );

    data_mem_sized #(.ADDR_W(8), .LATENCY(1), .INIT_WORDS(10)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .we(we1), .size(size1), .sign_ext(sign_ext1), .addr(addr1), .wdata(wdata1),
        .rvalid(rvalid1), .rdata(rdata1), .misalign(misalign1), .init_done(init_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 10; i++) ref_mem[4*i+3] = 8'(i);
    endtask

    function automatic bit ref_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se, input logic [31:0] a);
        int b = int'(a[7:0]);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = {24'h0, ref_mem[b]};
            if (se && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = {16'h0, ref_mem[b], ref_mem[b+1]};
            if (se && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int b = int'(a[7:0]);
        if (sz == 2'd0) begin
            ref_mem[b] = d[7:0];
        end else if (sz == 2'd1) begin
            ref_mem[b] = d[15:8]; ref_mem[b+1] = d[7:0];
        end else begin
            ref_mem[b] = d[31:24]; ref_mem[b+1] = d[23:16];
            ref_mem[b+2] = d[15:8]; ref_mem[b+3] = d[7:0];
        end
    endtask

    // One full transaction on the LATENCY=3 instance, checked against the model.
    task automatic access(input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        bit          exp_f;
        logic [31:0] exp_d;
        int          lat;
        exp_f = ref_fault(sz, a);
        exp_d = (w || exp_f) ? 32'h0 : ref_load(sz, se, a);
        @(negedge clk);
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        we = w; size = sz; sign_ext = se; addr = a; wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " rdata"}, rdata, exp_d);
        check({tag, " misalign"}, {31'h0, misalign}, {31'h0, exp_f});
        if (w && !exp_f) ref_store(sz, a, d);
    endtask

    initial begin
        int acc, rv, k_done;
        bit rv_seen;
        logic [1:0]  rsz;
        logic [31:0] ra;

        rst = 1'b1; req_valid = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        rst1 = 1'b1; req_valid1 = 1'b0; we1 = 1'b0; size1 = 2'b10; sign_ext1 = 1'b0;
        addr1 = 32'h0; wdata1 = 32'h0;
        model_init();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rvalid", {31'h0, rvalid}, 32'h0);
        check("rst rdata", rdata, 32'h0);
        check("rst misalign", {31'h0, misalign}, 32'h0);
        check("rst init_done", {31'h0, init_done}, 32'h0);
        check("rst req_ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b0; rst1 = 1'b0;

        // Initialisation sweep lasts exactly 64 cycles.
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("init_done c%0d", k), {31'h0, init_done}, {31'h0, k == 64});
            check($sformatf("req_ready c%0d", k), {31'h0, req_ready}, {31'h0, k == 64});
        end

        access(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, "lw 0x00");
        access(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, "lw 0x24");
        access(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, "lw 0x28");
        check("model word 9", ref_load(2'b10, 1'b0, 32'h24), 32'h9);

        access(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF7F01, "sw 0x40");
        access(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, "lb 0x40");
        access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, "lbu 0x40");
        access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, "lh 0x42");
        access(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, "lhu 0x42");
        check("model lb se", ref_load(2'b00, 1'b1, 32'h40), 32'hFFFF_FF80);

        access(1'b1, 2'b10, 1'b0, 32'h44, 32'h11223344, "sw 0x44");
        access(1'b1, 2'b00, 1'b0, 32'h45, 32'h000000AA, "sb 0x45");
        access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, "lw 0x44");
        check("model merge", ref_load(2'b10, 1'b0, 32'h44), 32'h11AA3344);

        access(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, "lh 0x41 mis");
        access(1'b1, 2'b10, 1'b0, 32'h42, 32'hFFFFFFFF, "sw 0x42 mis");
        access(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFFFFFF, "sz11 0x40");
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "lw 0x40 after");

        access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, "sw 0x104");
        access(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, "lw 0x04 wrap");

        // Randomized mix; low bits are cleared half the time to favour aligned hits.
        for (int i = 0; i < 200; i++) begin
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom,
                   $sformatf("rnd%0d", i));
        end

        // LATENCY=1 instance: next-edge response, wrap, and 1-per-2 throughput.
        @(negedge clk);
        check("l1 ready", {31'h0, req_ready1}, 32'h1);
        we1 = 1'b1; size1 = 2'b10; addr1 = 32'h104; wdata1 = 32'hDEADBEEF; req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        check("l1 sw rvalid", {31'h0, rvalid1}, 32'h1);
        check("l1 sw misalign", {31'h0, misalign1}, 32'h0);
        @(negedge clk);
        check("l1 pulse", {31'h0, rvalid1}, 32'h0);
        we1 = 1'b0; addr1 = 32'h04; req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        check("l1 lw rvalid", {31'h0, rvalid1}, 32'h1);
        check("l1 lw rdata", rdata1, 32'hDEADBEEF);
        @(negedge clk);
        addr1 = 32'h00; req_valid1 = 1'b1;
        acc = 0; rv = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready1) acc++;
            if (rvalid1) rv++;
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        check("l1 accepts/12", 32'(acc), 32'd6);
        check("l1 responses/12", 32'(rv), 32'd6);

        // Reset during WAIT abandons the pending store.
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h08; wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst rvalid", {31'h0, rvalid}, 32'h0);
        check("midrst init_done", {31'h0, init_done}, 32'h0);
        check("midrst req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rv_seen = 1'b0; k_done = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (rvalid) rv_seen = 1'b1;
            if (init_done) begin
                k_done = k;
                break;
            end
        end
        check("reinit cycles", 32'(k_done), 32'd64);
        check("midrst no rvalid", {31'h0, rv_seen}, 32'h0);
        model_init();
        access(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, "lw 0x08 reinit");
        check("model word 2", ref_load(2'b10, 1'b0, 32'h08), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
